// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush control slice.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, BR_FLUSH, LD_STALL} ctrl_state_e;

  localparam int REG_ADDR_W = 5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Hazard inputs from the ID/EX stages and stall/flush controls back to the pipeline.
interface hazard_flush_ctrl_if #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
);

  logic                  branch_taken_i;
  logic                  id_ex_memread_i;
  logic [REG_ADDR_W-1:0] id_ex_rd_i;
  logic [REG_ADDR_W-1:0] if_id_rs1_i;
  logic [REG_ADDR_W-1:0] if_id_rs2_i;
  logic                  if_id_rs1_used_i;
  logic                  if_id_rs2_used_i;

  logic                  pc_stall_o;
  logic                  if_id_stall_o;
  logic                  if_id_flush_o;
  logic                  id_ex_flush_o;
  logic                  busy_o;

  // master: the control unit; slave: the pipeline that feeds it and obeys it
  modport master (
    input  branch_taken_i, id_ex_memread_i, id_ex_rd_i,
    input  if_id_rs1_i, if_id_rs2_i, if_id_rs1_used_i, if_id_rs2_used_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, busy_o
  );

  modport slave (
    output branch_taken_i, id_ex_memread_i, id_ex_rd_i,
    output if_id_rs1_i, if_id_rs2_i, if_id_rs1_used_i, if_id_rs2_used_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, busy_o
  );

endinterface

// File: rtl/hazard_flush_ctrl_load_use_detect.sv
// Combinational load-use comparator: ID source registers vs. the destination of a load in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic              memread,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              hit
);

  // x0 is hardwired to zero, so a load into it can never create a dependency
  assign hit = memread && (rd != '0) &&
               ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline stall/flush controller: branch flush and load-use bubbles for 1-cycle-latency SRAMs.
// Mealy reaction in RUN, Moore while a multi-cycle bubble is in progress; outputs held at 0 in reset.
module hazard_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W      = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int BR_FLUSH_CYCLES = 2,
  parameter int LD_STALL_CYCLES = 2
) (
  input logic                clk_i,
  input logic                rst_ni,
  hazard_flush_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(max_int(BR_FLUSH_CYCLES, LD_STALL_CYCLES) + 1);
  localparam logic [CNT_W-1:0] BR_LOAD =
    CNT_W'((BR_FLUSH_CYCLES > 1) ? BR_FLUSH_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] LD_LOAD =
    CNT_W'((LD_STALL_CYCLES > 1) ? LD_STALL_CYCLES - 2 : 0);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ld_hit;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_flush;

  load_use_detect #(.ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .memread  (bus.id_ex_memread_i),
    .rd       (bus.id_ex_rd_i),
    .rs1      (bus.if_id_rs1_i),
    .rs2      (bus.if_id_rs2_i),
    .rs1_used (bus.if_id_rs1_used_i),
    .rs2_used (bus.if_id_rs2_used_i),
    .hit      (ld_hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    // A taken branch is older than anything in ID and restarts the flush from any state
    if (bus.branch_taken_i) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      if (BR_FLUSH_CYCLES > 1) begin
        state_d = BR_FLUSH;
        cnt_d   = BR_LOAD;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (ld_hit) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LD_STALL_CYCLES > 1) begin
              state_d = LD_STALL;
              cnt_d   = LD_LOAD;
            end
          end
        end
        BR_FLUSH: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        LD_STALL: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Mealy paths would otherwise leak input activity while the reset is held
  assign bus.pc_stall_o    = rst_ni & pc_stall;
  assign bus.if_id_stall_o = rst_ni & if_id_stall;
  assign bus.if_id_flush_o = rst_ni & if_id_flush;
  assign bus.id_ex_flush_o = rst_ni & id_ex_flush;
  assign bus.busy_o        = rst_ni & (state_q != RUN);

endmodule
